// File: rtl/alu_exec_unit.sv
// Single-cycle integer execution unit for the out-of-order RV32I core.
// Computes one RS-issued op per cycle and registers result + ROB tag for the CDB.
// JALR additionally produces a one-cycle redirect to instruction fetch.
module alu_exec_unit #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned VAL_WIDTH    = 32,
    parameter int unsigned OP_WIDTH     = 7,
    parameter int unsigned ROB_ID_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush,
    input  logic                    execute,
    input  logic [OP_WIDTH-1:0]     op_type,
    input  logic [VAL_WIDTH-1:0]    val1,
    input  logic [VAL_WIDTH-1:0]    val2,
    input  logic [ROB_ID_WIDTH:0]   entry,
    input  logic [ADDR_WIDTH-1:0]   nowPC,
    output logic                    aluReady,
    output logic [ROB_ID_WIDTH:0]   entry_out,
    output logic [VAL_WIDTH-1:0]    val_out,
    output logic [ADDR_WIDTH-1:0]   alu2if_pc,
    output logic                    alu2if_con
);

    // Group field in the upper op bits, op index in the low nibble.
    localparam logic [2:0] GrpR      = 3'd0;
    localparam logic [2:0] GrpI      = 3'd1;
    localparam logic [2:0] GrpBranch = 3'd2;
    localparam logic [2:0] GrpOther  = 3'd3;

    logic [2:0]           group;
    logic [3:0]           low;
    logic [4:0]           shamt;
    logic [VAL_WIDTH-1:0] sum;
    logic [VAL_WIDTH-1:0] diff;
    logic [VAL_WIDTH-1:0] jalr_target;
    logic                 lt_s;
    logic                 lt_u;
    logic                 eq;
    logic [VAL_WIDTH-1:0] result;
    logic                 is_jalr;

    logic                  ready_q;
    logic                  con_q;
    logic [ROB_ID_WIDTH:0] entry_q;
    logic [VAL_WIDTH-1:0]  val_q;
    logic [ADDR_WIDTH-1:0] pc_q;

    // The decoder PC is carried on the port for debug only.
    logic unused_now_pc;
    assign unused_now_pc = ^nowPC;

    assign group       = op_type[6:4];
    assign low         = op_type[3:0];
    assign shamt       = val2[4:0];
    assign sum         = val1 + val2;
    assign diff        = val1 - val2;
    assign jalr_target = {sum[VAL_WIDTH-1:1], 1'b0};
    assign lt_s        = $signed(val1) < $signed(val2);
    assign lt_u        = val1 < val2;
    assign eq          = val1 == val2;

    // Combinational result for the op currently being issued; unknown ops yield 0.
    always_comb begin
        result  = '0;
        is_jalr = 1'b0;
        unique case (group)
            GrpR, GrpI: begin
                case (low)
                    4'h0: result = sum;
                    4'h1: result = (group == GrpR) ? diff : '0;  // no SUBI
                    4'h2: result = val1 << shamt;
                    4'h3: result = {{(VAL_WIDTH-1){1'b0}}, lt_s};
                    4'h4: result = {{(VAL_WIDTH-1){1'b0}}, lt_u};
                    4'h5: result = val1 ^ val2;
                    4'h6: result = val1 >> shamt;
                    4'h7: result = $unsigned($signed(val1) >>> shamt);
                    4'h8: result = val1 | val2;
                    4'h9: result = val1 & val2;
                    4'hA: begin
                        if (group == GrpI) begin
                            result  = jalr_target;
                            is_jalr = 1'b1;
                        end
                    end
                    default: result = '0;
                endcase
            end
            GrpBranch: begin
                case (low)
                    4'h0:    result = {{(VAL_WIDTH-1){1'b0}}, eq};
                    4'h1:    result = {{(VAL_WIDTH-1){1'b0}}, !eq};
                    4'h4:    result = {{(VAL_WIDTH-1){1'b0}}, lt_s};
                    4'h5:    result = {{(VAL_WIDTH-1){1'b0}}, !lt_s};
                    4'h6:    result = {{(VAL_WIDTH-1){1'b0}}, lt_u};
                    4'h7:    result = {{(VAL_WIDTH-1){1'b0}}, !lt_u};
                    default: result = '0;
                endcase
            end
            GrpOther: begin
                case (low)
                    4'h0:    result = val1;
                    4'h1:    result = sum;
                    4'h2:    result = sum;
                    default: result = '0;
                endcase
            end
            default: result = '0;
        endcase
    end

    // Output registers: flush squashes, execute loads, idle drops the strobes, stall holds.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            ready_q <= 1'b0;
            con_q   <= 1'b0;
            entry_q <= '0;
            val_q   <= '0;
            pc_q    <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                ready_q <= 1'b0;
                con_q   <= 1'b0;
                entry_q <= '0;
            end else if (execute) begin
                ready_q <= 1'b1;
                entry_q <= entry;
                val_q   <= result;
                con_q   <= is_jalr;
                if (is_jalr) begin
                    pc_q <= ADDR_WIDTH'(jalr_target);
                end
            end else begin
                ready_q <= 1'b0;
                con_q   <= 1'b0;
            end
        end
    end

    assign aluReady   = ready_q;
    assign entry_out  = entry_q;
    assign val_out    = val_q;
    assign alu2if_pc  = pc_q;
    assign alu2if_con = con_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised self-checking bench for alu_exec_unit against a behavioural model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        execute;
    logic [6:0]  op_type;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [3:0]  entry;
    logic [31:0] now_pc;
    logic        alu_ready;
    logic [3:0]  entry_out;
    logic [31:0] val_out;
    logic [31:0] alu2if_pc;
    logic        alu2if_con;

    int n_total = 0;
    int n_bad   = 0;

    // Model of the registered outputs.
    logic        m_ready;
    logic        m_con;
    logic [3:0]  m_entry;
    logic [31:0] m_val;
    logic [31:0] m_pc;

    logic [6:0] valid_ops [32] = '{
        7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07, 7'h08, 7'h09,
        7'h10, 7'h12, 7'h13, 7'h14, 7'h15, 7'h16, 7'h17, 7'h18, 7'h19, 7'h1A,
        7'h20, 7'h21, 7'h24, 7'h25, 7'h26, 7'h27, 7'h30, 7'h31, 7'h32,
        7'h11, 7'h0C, 7'h22
    };

    alu_exec_unit #(
        .ADDR_WIDTH   (32),
        .VAL_WIDTH    (32),
        .OP_WIDTH     (7),
        .ROB_ID_WIDTH (3)
    ) dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .flush      (flush),
        .execute    (execute),
        .op_type    (op_type),
        .val1       (val1),
        .val2       (val2),
        .entry      (entry),
        .nowPC      (now_pc),
        .aluReady   (alu_ready),
        .entry_out  (entry_out),
        .val_out    (val_out),
        .alu2if_pc  (alu2if_pc),
        .alu2if_con (alu2if_con)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Arithmetic reference: results derived from the ISA meaning of each op.
    function automatic logic [31:0] ref_result(input logic [6:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa  = longint'($signed(a));
        longint      sb  = longint'($signed(b));
        longint      tmp;
        int unsigned sh  = int'(b[4:0]);
        logic [31:0] pow = 32'd1 << sh;
        // I-group ops are their R-group counterparts with an immediate operand.
        if (op[6:4] == 3'd1 && op[3:0] != 4'h1 && op[3:0] <= 4'h9)
            return ref_result({3'd0, op[3:0]}, a, b);
        case (op)
            7'h00: return a + b;
            7'h01: return a - b;
            7'h02: return a * pow;
            7'h03: return (sa < sb) ? 32'd1 : 32'd0;
            7'h04: return (a < b) ? 32'd1 : 32'd0;
            7'h05: return a ^ b;
            7'h06: return a / pow;
            7'h07: begin
                tmp = sa >>> sh;
                return tmp[31:0];
            end
            7'h08: return a | b;
            7'h09: return a & b;
            7'h1A: return (a + b) & 32'hFFFF_FFFE;
            7'h20: return (a == b) ? 32'd1 : 32'd0;
            7'h21: return (a != b) ? 32'd1 : 32'd0;
            7'h24: return (sa < sb) ? 32'd1 : 32'd0;
            7'h25: return (sa >= sb) ? 32'd1 : 32'd0;
            7'h26: return (a < b) ? 32'd1 : 32'd0;
            7'h27: return (a >= b) ? 32'd1 : 32'd0;
            7'h30: return a;
            7'h31: return a + b;
            7'h32: return a + b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_ready = 1'b0;
        m_con   = 1'b0;
        m_entry = '0;
        m_val   = '0;
        m_pc    = '0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ready"}, {31'd0, alu_ready}, {31'd0, m_ready});
        check({tag, ".entry"}, {28'd0, entry_out}, {28'd0, m_entry});
        check({tag, ".val"}, val_out, m_val);
        check({tag, ".pc"}, alu2if_pc, m_pc);
        check({tag, ".con"}, {31'd0, alu2if_con}, {31'd0, m_con});
    endtask

    // Apply inputs, clock once, advance the model, compare 1 ns after the edge.
    task automatic step(input string tag, input logic [6:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] e, input logic ex,
                        input logic fl, input logic rdy);
        op_type = op;
        val1    = a;
        val2    = b;
        entry   = e;
        execute = ex;
        flush   = fl;
        rdy_in  = rdy;
        now_pc  = $urandom;
        @(posedge clk);
        if (rdy) begin
            if (fl) begin
                m_ready = 1'b0;
                m_con   = 1'b0;
                m_entry = '0;
            end else if (ex) begin
                m_ready = 1'b1;
                m_entry = e;
                m_val   = ref_result(op, a, b);
                m_con   = (op == 7'h1A);
                if (op == 7'h1A) m_pc = m_val;
            end else begin
                m_ready = 1'b0;
                m_con   = 1'b0;
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_in  = 1'b1;
        rdy_in  = 1'b1;
        flush   = 1'b0;
        execute = 1'b0;
        op_type = '0;
        val1    = '0;
        val2    = '0;
        entry   = '0;
        now_pc  = '0;
        model_reset();
        #12;
        check_all("reset");
        rst_in = 1'b0;

        step("add", 7'h00, 32'd7, 32'hFFFF_FFFF, 4'd3, 1'b1, 1'b0, 1'b1);
        check("add.val_const", val_out, 32'd6);
        check("add.entry_const", {28'd0, entry_out}, 32'd3);
        step("idle", 7'h00, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        check("idle.ready_const", {31'd0, alu_ready}, 32'd0);

        step("sra", 7'h07, 32'h8000_0000, 32'h24, 4'd1, 1'b1, 1'b0, 1'b1);
        check("sra.val_const", val_out, 32'hF800_0000);
        step("sltu", 7'h04, 32'd1, 32'hFFFF_FFFF, 4'd2, 1'b1, 1'b0, 1'b1);
        check("sltu.val_const", val_out, 32'd1);
        step("slt", 7'h03, 32'd1, 32'hFFFF_FFFF, 4'd2, 1'b1, 1'b0, 1'b1);
        check("slt.val_const", val_out, 32'd0);

        step("jalr", 7'h1A, 32'h1001, 32'h10, 4'd5, 1'b1, 1'b0, 1'b1);
        check("jalr.pc_const", alu2if_pc, 32'h1010);
        check("jalr.con_const", {31'd0, alu2if_con}, 32'd1);
        check("jalr.val_const", val_out, 32'h1010);
        step("blt", 7'h24, 32'hFFFF_FFFF, 32'd1, 4'd6, 1'b1, 1'b0, 1'b1);
        check("blt.val_const", val_out, 32'd1);
        check("blt.con_const", {31'd0, alu2if_con}, 32'd0);
        check("blt.pc_hold", alu2if_pc, 32'h1010);
        step("bgeu", 7'h27, 32'hFFFF_FFFF, 32'd1, 4'd6, 1'b1, 1'b0, 1'b1);
        check("bgeu.val_const", val_out, 32'd1);
        step("beq", 7'h20, 32'd5, 32'd6, 4'd7, 1'b1, 1'b0, 1'b1);
        check("beq.val_const", val_out, 32'd0);

        step("stall", 7'h00, 32'd9, 32'd9, 4'd2, 1'b1, 1'b0, 1'b0);
        check("stall.ready_const", {31'd0, alu_ready}, 32'd1);
        check("stall.entry_const", {28'd0, entry_out}, 32'd7);

        step("undef", 7'h11, 32'd3, 32'd4, 4'd4, 1'b1, 1'b0, 1'b1);
        check("undef.val_const", val_out, 32'd0);
        check("undef.ready_const", {31'd0, alu_ready}, 32'd1);

        step("flush", 7'h00, 32'd1, 32'd2, 4'd3, 1'b1, 1'b1, 1'b1);
        check("flush.ready_const", {31'd0, alu_ready}, 32'd0);
        check("flush.entry_const", {28'd0, entry_out}, 32'd0);

        // Asynchronous reset between edges while a result is pending.
        step("pre_rst", 7'h00, 32'd10, 32'd20, 4'd9, 1'b1, 1'b0, 1'b1);
        execute = 1'b0;
        #2;
        rst_in = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #1;
        rst_in = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            logic [6:0] op;
            if ($urandom_range(9) == 0) op = 7'($urandom);
            else op = valid_ops[$urandom_range(31)];
            step("rand", op, $urandom, ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom,
                 4'($urandom), ($urandom_range(9) < 7), ($urandom_range(19) == 0),
                 ($urandom_range(9) != 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
